sc_obc_ddr_bist: RTL

- Parametrised AXI4 memory built-in self-test (BIST) master for the DDR4 region behind the Versal PS block design.
- Attached to a PL-to-NoC AXI slave port.
- Writes a deterministic, address-derived pattern over a software-selected region, reads it back, and compares.
- Reports mismatch count, first failing address, and bus-response errors. Used for board bring-up and on-orbit memory health checks.

---
 rtl/sc_obc_ddr_bist_pkg.sv | 22 ++
 rtl/sc_obc_ddr_bist_pattern.sv | 23 ++
 rtl/sc_obc_ddr_bist.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sc_obc_ddr_bist_pkg.sv
// Shared types and AXI constants for the DDR4 memory BIST master.
// Imported by the top level and the pattern generator.
package sc_obc_ddr_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_FINISH
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic logic [2:0] axsize(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/sc_obc_ddr_bist_pattern.sv
// Address-derived test pattern: each 32-bit lane is (A + 4*i) ^ seed.
// Purely combinational, shared by the write and read-compare paths.
module sc_obc_ddr_bist_pattern #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       seed_i,
  output logic [DATA_W-1:0] data_o
);

  logic [31:0] a32;

  assign a32 = 32'(addr_i);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < DATA_W / 32; i++) begin
      data_o[32*i +: 32] = (a32 + 32'(4 * i)) ^ seed_i;
    end
  end

endmodule

// File: rtl/sc_obc_ddr_bist.sv
// AXI4 write/read-back/compare BIST master for the DDR4 region.
// One outstanding transaction; ABORT takes effect at the next AW/AR issue point.
module sc_obc_ddr_bist
  import sc_obc_ddr_bist_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 16,
  parameter int NB_W      = 20
) (
  input  logic                CLK,
  input  logic                XRST,
  input  logic                START,
  input  logic                ABORT,
  input  logic [ADDR_W-1:0]   BASE_ADDR,
  input  logic [NB_W-1:0]     NUM_BURSTS,
  input  logic [31:0]         SEED,
  output logic                BUSY,
  output logic                DONE,
  output logic                ABORTED,
  output logic                RESP_ERR,
  output logic [15:0]         ERR_CNT,
  output logic [ADDR_W-1:0]   FIRST_ERR_ADDR,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [7:0]          M_AXI_AWLEN,
  output logic [2:0]          M_AXI_AWSIZE,
  output logic [1:0]          M_AXI_AWBURST,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WLAST,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [7:0]          M_AXI_ARLEN,
  output logic [2:0]          M_AXI_ARSIZE,
  output logic [1:0]          M_AXI_ARBURST,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RLAST,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);

  localparam int BYTES = DATA_W / 8;
  localparam int BLK   = BURST_LEN * BYTES;
  localparam int LBLK  = $clog2(BLK);
  localparam int SZ    = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] BLK_A = ADDR_W'(BLK);
  localparam logic [ADDR_W-1:0] ALIGN = {ADDR_W{1'b1}} << LBLK;
  localparam logic [7:0] LAST = 8'(BURST_LEN - 1);
  localparam logic [NB_W-1:0] ONE = NB_W'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q, base_q, ferr_q;
  logic [NB_W-1:0]   rem_q, nb_q;
  logic [31:0]       seed_q;
  logic [7:0]        beat_q;
  logic [15:0]       err_cnt_q;
  logic abort_q, busy_q, done_q, aborted_q, resp_err_q;
  logic awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] wpat, rpat;
  logic              abort_now;

  assign beat_addr = addr_q + (ADDR_W'(beat_q) << SZ);
  assign abort_now = abort_q | ABORT;

  sc_obc_ddr_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wpat (
    .addr_i(beat_addr), .seed_i(seed_q), .data_o(wpat)
  );

  sc_obc_ddr_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rpat (
    .addr_i(beat_addr), .seed_i(seed_q), .data_o(rpat)
  );

  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      base_q     <= '0;
      ferr_q     <= '0;
      rem_q      <= '0;
      nb_q       <= '0;
      seed_q     <= '0;
      beat_q     <= '0;
      err_cnt_q  <= '0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      resp_err_q <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      if (busy_q && ABORT) abort_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: if (START) begin
          base_q     <= BASE_ADDR & ALIGN;
          addr_q     <= BASE_ADDR & ALIGN;
          nb_q       <= NUM_BURSTS;
          rem_q      <= NUM_BURSTS;
          seed_q     <= SEED;
          beat_q     <= '0;
          err_cnt_q  <= '0;
          ferr_q     <= '0;
          resp_err_q <= 1'b0;
          aborted_q  <= 1'b0;
          done_q     <= 1'b0;
          abort_q    <= 1'b0;
          busy_q     <= 1'b1;
          if (NUM_BURSTS == '0) begin
            state_q <= ST_FINISH;
          end else begin
            state_q   <= ST_WR_ADDR;
            awvalid_q <= 1'b1;
          end
        end
        ST_WR_ADDR: if (M_AXI_AWREADY) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b1;
          state_q   <= ST_WR_DATA;
        end
        ST_WR_DATA: if (M_AXI_WREADY) begin
          if (beat_q == LAST) begin
            beat_q   <= '0;
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end else begin
            beat_q <= beat_q + 8'd1;
          end
        end
        ST_WR_RESP: if (M_AXI_BVALID) begin
          bready_q <= 1'b0;
          if (M_AXI_BRESP != RESP_OKAY) resp_err_q <= 1'b1;
          if (rem_q == ONE) begin
            rem_q  <= nb_q;
            addr_q <= base_q;
          end else begin
            rem_q  <= rem_q - ONE;
            addr_q <= addr_q + BLK_A;
          end
          if (abort_now) begin
            aborted_q <= 1'b1;
            state_q   <= ST_FINISH;
          end else if (rem_q == ONE) begin
            arvalid_q <= 1'b1;
            state_q   <= ST_RD_ADDR;
          end else begin
            awvalid_q <= 1'b1;
            state_q   <= ST_WR_ADDR;
          end
        end
        ST_RD_ADDR: if (M_AXI_ARREADY) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= ST_RD_DATA;
        end
        ST_RD_DATA: if (M_AXI_RVALID) begin
          beat_q <= beat_q + 8'd1;
          if (M_AXI_RRESP != RESP_OKAY) resp_err_q <= 1'b1;
          if (M_AXI_RDATA != rpat) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            if (err_cnt_q == 16'd0) ferr_q <= beat_addr;
          end
          if (M_AXI_RLAST) begin
            // A short or long burst is a slave protocol fault
            if (beat_q != LAST) resp_err_q <= 1'b1;
            beat_q   <= '0;
            rready_q <= 1'b0;
            if (rem_q == ONE) begin
              state_q <= ST_FINISH;
            end else begin
              rem_q  <= rem_q - ONE;
              addr_q <= addr_q + BLK_A;
              if (abort_now) begin
                aborted_q <= 1'b1;
                state_q   <= ST_FINISH;
              end else begin
                arvalid_q <= 1'b1;
                state_q   <= ST_RD_ADDR;
              end
            end
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign ABORTED        = aborted_q;
  assign RESP_ERR       = resp_err_q;
  assign ERR_CNT        = err_cnt_q;
  assign FIRST_ERR_ADDR = ferr_q;

  // Fixed AXI fields are gated so that every output reads 0 out of reset
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = awvalid_q ? LAST : 8'd0;
  assign M_AXI_AWSIZE  = awvalid_q ? axsize(DATA_W) : 3'd0;
  assign M_AXI_AWBURST = awvalid_q ? BURST_INCR : 2'b00;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wvalid_q ? wpat : '0;
  assign M_AXI_WSTRB   = {(DATA_W/8){wvalid_q}};
  assign M_AXI_WLAST   = wvalid_q && (beat_q == LAST);
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = arvalid_q ? LAST : 8'd0;
  assign M_AXI_ARSIZE  = arvalid_q ? axsize(DATA_W) : 3'd0;
  assign M_AXI_ARBURST = arvalid_q ? BURST_INCR : 2'b00;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
